// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the system RAM arbiter: FSM state encodings,
//   requester IDs and the width of the read-latency counter.
//   No ports; imported by mem_arb_select and mem_port_arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LDR = 1'b1
  } req_id_t;

  // Wide enough for a read latency of up to 3 cycles.
  localparam int LAT_CNT_W = 2;

endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select
//   Combinational winner selection between the CPU and loader requesters,
//   plus the registered loader-streak counter that stops the loader from
//   starving the CPU.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous, active-low reset
//   cpu_req  in   CPU request level
//   ldr_req  in   loader request level
//   decide   in   high in the cycle the arbiter commits to a winner
//   winner   out  requester chosen by the current inputs and streak
module mem_arb_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int LOADER_BURST = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    cpu_req,
  input  logic    ldr_req,
  input  logic    decide,
  output req_id_t winner
);

  localparam int SW = $clog2(LOADER_BURST + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(LOADER_BURST);

  logic [SW-1:0] streak;
  logic          cpu_turn;

  // Once the loader has used up its burst while the CPU waits, the CPU
  // takes the next slot even though the loader still has priority.
  assign cpu_turn = cpu_req && (streak == STREAK_MAX);

  always_comb begin
    winner = REQ_CPU;
    if (ldr_req && !cpu_turn) begin
      winner = REQ_LDR;
    end
  end

  // Streak only counts loader grants that happened while the CPU was
  // waiting; any cycle without a CPU request forgets the history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (!cpu_req) begin
      streak <= '0;
    end else if (decide) begin
      if (winner == REQ_CPU) begin
        streak <= '0;
      end else if (streak != STREAK_MAX) begin
        streak <= streak + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port synchronous system RAM between the CPU memory
//   path and the boot/debug loader port, one transaction at a time, with
//   registered RAM commands and a configurable read latency.
// Ports:
//   clk, in_reset_n                       clock / async active-low reset
//   in_cpu_req/we/addr/wdata              CPU request (held until gnt)
//   out_cpu_gnt/rvalid/rdata              CPU grant pulse, read response
//   in_ldr_req/we/addr/wdata              loader request (held until gnt)
//   out_ldr_gnt/rvalid/rdata              loader grant pulse, read response
//   out_ram_en/we/addr/wdata, in_ram_rdata  RAM command and read data
//   out_busy                              high whenever not idle
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int LOADER_BURST = 4
) (
  input  logic                  clk,
  input  logic                  in_reset_n,
  input  logic                  in_cpu_req,
  input  logic                  in_cpu_we,
  input  logic [ADDR_WIDTH-1:0] in_cpu_addr,
  input  logic [DATA_WIDTH-1:0] in_cpu_wdata,
  output logic                  out_cpu_gnt,
  output logic                  out_cpu_rvalid,
  output logic [DATA_WIDTH-1:0] out_cpu_rdata,
  input  logic                  in_ldr_req,
  input  logic                  in_ldr_we,
  input  logic [ADDR_WIDTH-1:0] in_ldr_addr,
  input  logic [DATA_WIDTH-1:0] in_ldr_wdata,
  output logic                  out_ldr_gnt,
  output logic                  out_ldr_rvalid,
  output logic [DATA_WIDTH-1:0] out_ldr_rdata,
  output logic                  out_ram_en,
  output logic                  out_ram_we,
  output logic [ADDR_WIDTH-1:0] out_ram_addr,
  output logic [DATA_WIDTH-1:0] out_ram_wdata,
  input  logic [DATA_WIDTH-1:0] in_ram_rdata,
  output logic                  out_busy
);

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(READ_LATENCY);

  arb_state_t           state;
  arb_state_t           next_state;
  req_id_t              winner;
  req_id_t              owner;
  logic                 decide;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic                 lat_done;

  assign decide   = (state == ST_IDLE) && (in_cpu_req || in_ldr_req);
  // The count hits zero on the edge that ends this cycle.
  assign lat_done = (lat_cnt == LAT_CNT_W'(1));

  mem_arb_select #(
    .LOADER_BURST(LOADER_BURST)
  ) u_select (
    .clk    (clk),
    .rst_n  (in_reset_n),
    .cpu_req(in_cpu_req),
    .ldr_req(in_ldr_req),
    .decide (decide),
    .winner (winner)
  );

  always_ff @(posedge clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (decide) next_state = ST_ISSUE;
      ST_ISSUE: next_state = out_ram_we ? ST_IDLE : ST_WAIT;
      ST_WAIT:  if (lat_done) next_state = ST_RESP;
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    out_busy       = (state != ST_IDLE);
    out_ram_en     = (state == ST_ISSUE);
    out_cpu_gnt    = (state == ST_ISSUE) && (owner == REQ_CPU);
    out_ldr_gnt    = (state == ST_ISSUE) && (owner == REQ_LDR);
    out_cpu_rvalid = (state == ST_RESP)  && (owner == REQ_CPU);
    out_ldr_rvalid = (state == ST_RESP)  && (owner == REQ_LDR);
  end

  // Requester fields are captured only at the decision edge, so the RAM
  // command stays stable until the next decision regardless of what the
  // requesters do afterwards.
  always_ff @(posedge clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      owner         <= REQ_CPU;
      out_ram_we    <= 1'b0;
      out_ram_addr  <= '0;
      out_ram_wdata <= '0;
      lat_cnt       <= '0;
      out_cpu_rdata <= '0;
      out_ldr_rdata <= '0;
    end else begin
      if (decide) begin
        owner <= winner;
        if (winner == REQ_LDR) begin
          out_ram_we    <= in_ldr_we;
          out_ram_addr  <= in_ldr_addr;
          out_ram_wdata <= in_ldr_wdata;
        end else begin
          out_ram_we    <= in_cpu_we;
          out_ram_addr  <= in_cpu_addr;
          out_ram_wdata <= in_cpu_wdata;
        end
      end
      if (state == ST_ISSUE) begin
        lat_cnt <= LAT_INIT;
      end
      if (state == ST_WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
        if (lat_done) begin
          if (owner == REQ_LDR) begin
            out_ldr_rdata <= in_ram_rdata;
          end else begin
            out_cpu_rdata <= in_ram_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter with a latency-3 RAM model,
//   a transaction-level reference model and randomized requesters.
module tb_mem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int RL = 3;
  localparam int LB = 4;

  logic          clk;
  logic          in_reset_n;
  logic          in_cpu_req, in_cpu_we;
  logic [AW-1:0] in_cpu_addr;
  logic [DW-1:0] in_cpu_wdata;
  logic          out_cpu_gnt, out_cpu_rvalid;
  logic [DW-1:0] out_cpu_rdata;
  logic          in_ldr_req, in_ldr_we;
  logic [AW-1:0] in_ldr_addr;
  logic [DW-1:0] in_ldr_wdata;
  logic          out_ldr_gnt, out_ldr_rvalid;
  logic [DW-1:0] out_ldr_rdata;
  logic          out_ram_en, out_ram_we;
  logic [AW-1:0] out_ram_addr;
  logic [DW-1:0] out_ram_wdata;
  logic [DW-1:0] in_ram_rdata;
  logic          out_busy;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .LOADER_BURST(LB)
  ) dut (
    .clk(clk), .in_reset_n(in_reset_n),
    .in_cpu_req(in_cpu_req), .in_cpu_we(in_cpu_we), .in_cpu_addr(in_cpu_addr),
    .in_cpu_wdata(in_cpu_wdata), .out_cpu_gnt(out_cpu_gnt),
    .out_cpu_rvalid(out_cpu_rvalid), .out_cpu_rdata(out_cpu_rdata),
    .in_ldr_req(in_ldr_req), .in_ldr_we(in_ldr_we), .in_ldr_addr(in_ldr_addr),
    .in_ldr_wdata(in_ldr_wdata), .out_ldr_gnt(out_ldr_gnt),
    .out_ldr_rvalid(out_ldr_rvalid), .out_ldr_rdata(out_ldr_rdata),
    .out_ram_en(out_ram_en), .out_ram_we(out_ram_we), .out_ram_addr(out_ram_addr),
    .out_ram_wdata(out_ram_wdata), .in_ram_rdata(in_ram_rdata), .out_busy(out_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Power-on RAM contents; 0x1FF carries a recognisable pattern.
  function automatic logic [31:0] init_val(input logic [8:0] a);
    if (a == 9'h1FF) return 32'h12345678;
    return 32'hA5000000 ^ (32'(a) * 32'h00010101);
  endfunction

  function automatic logic [8:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 9'h1FF;
    return 9'($urandom_range(0, 15));
  endfunction

  // Synchronous RAM: en sampled at a rising edge, read data appears RL
  // edges later. Unused pipeline slots carry garbage so a mistimed capture
  // shows up as wrong data.
  logic [31:0] ram_mem [512];
  bit          ram_written [512];
  logic [31:0] pipe [RL];

  always @(posedge clk) begin
    if (out_ram_en && out_ram_we) begin
      ram_mem[out_ram_addr]     <= out_ram_wdata;
      ram_written[out_ram_addr] <= 1'b1;
    end
    if (out_ram_en && !out_ram_we)
      pipe[0] <= ram_written[out_ram_addr] ? ram_mem[out_ram_addr] : init_val(out_ram_addr);
    else
      pipe[0] <= $urandom;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign in_ram_rdata = pipe[RL-1];

  // Reference model: a transaction decided at edge d grants in the cycle
  // after d, a read responds in the cycle after edge d+RL+1, and the next
  // decision may happen at edge d+2 (write) or d+RL+3 (read).
  int          edge_n, dec_edge, next_free, streak;
  bit          has_txn, t_ldr, t_we, ldr_wins, decided;
  logic [8:0]  t_addr;
  logic [31:0] t_wdata, t_rval;
  logic [31:0] exp_rdata [2];
  logic [31:0] ref_mem [512];
  bit          ref_written [512];

  initial begin
    forever begin
      @(posedge clk or negedge in_reset_n);
      if (!in_reset_n) begin
        edge_n = 0; dec_edge = 0; next_free = 0; streak = 0;
        has_txn = 0; t_ldr = 0; t_we = 0; t_addr = '0; t_wdata = '0; t_rval = '0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
      end else begin
        edge_n++;
        if (has_txn && t_we && edge_n == dec_edge + 1) begin
          ref_mem[t_addr] = t_wdata;
          ref_written[t_addr] = 1'b1;
        end
        if (has_txn && !t_we && edge_n == dec_edge + RL + 1) exp_rdata[t_ldr] = t_rval;
        ldr_wins = in_ldr_req && !(in_cpu_req && streak == LB);
        decided = 0;
        if (edge_n >= next_free && (in_cpu_req || in_ldr_req)) begin
          decided  = 1;
          has_txn  = 1;
          dec_edge = edge_n;
          t_ldr    = ldr_wins;
          t_we     = ldr_wins ? in_ldr_we    : in_cpu_we;
          t_addr   = ldr_wins ? in_ldr_addr  : in_cpu_addr;
          t_wdata  = ldr_wins ? in_ldr_wdata : in_cpu_wdata;
          t_rval   = ref_written[t_addr] ? ref_mem[t_addr] : init_val(t_addr);
          next_free = edge_n + (t_we ? 2 : RL + 3);
        end
        if (!in_cpu_req) streak = 0;
        else if (decided) streak = ldr_wins ? ((streak < LB) ? streak + 1 : streak) : 0;
      end
    end
  end

  // Cycle-by-cycle comparison of every DUT output against the model.
  int age;
  bit exp_gnt, exp_rv, exp_busy;

  initial begin
    forever begin
      @(negedge clk);
      age      = edge_n - dec_edge;
      exp_gnt  = has_txn && age == 0;
      exp_rv   = has_txn && !t_we && age == RL + 1;
      exp_busy = has_txn && (age < (t_we ? 1 : RL + 2));
      checkOutput("cpu_gnt",    out_cpu_gnt,    exp_gnt && !t_ldr);
      checkOutput("ldr_gnt",    out_ldr_gnt,    exp_gnt && t_ldr);
      checkOutput("cpu_rvalid", out_cpu_rvalid, exp_rv && !t_ldr);
      checkOutput("ldr_rvalid", out_ldr_rvalid, exp_rv && t_ldr);
      checkOutput("cpu_rdata",  out_cpu_rdata,  exp_rdata[0]);
      checkOutput("ldr_rdata",  out_ldr_rdata,  exp_rdata[1]);
      checkOutput("ram_en",     out_ram_en,     exp_gnt);
      checkOutput("ram_we",     out_ram_we,     t_we);
      checkOutput("ram_addr",   out_ram_addr,   t_addr);
      checkOutput("ram_wdata",  out_ram_wdata,  t_wdata);
      checkOutput("busy",       out_busy,       exp_busy);
    end
  end

  // Asserts reset away from the clock edges, confirms the outputs clear at
  // once, and releases it again between edges.
  task automatic pulseReset(input int hold);
    #2 in_reset_n = 1'b0;
    in_cpu_req = 1'b0;
    in_ldr_req = 1'b0;
    #1;
    checkOutput("rst_ctrl", {out_busy, out_ram_en, out_ram_we, out_cpu_gnt, out_ldr_gnt,
                             out_cpu_rvalid, out_ldr_rvalid, out_ram_addr}, 64'd0);
    checkOutput("rst_wdata", out_ram_wdata, 64'd0);
    checkOutput("rst_cpu_rdata", out_cpu_rdata, 64'd0);
    checkOutput("rst_ldr_rdata", out_ldr_rdata, 64'd0);
    repeat (hold) @(negedge clk);
    #2 in_reset_n = 1'b1;
  endtask

  task automatic waitIdle();
    int w = 0;
    while (out_busy && w < 50) begin
      @(negedge clk);
      w++;
    end
    checkOutput("wait_idle", out_busy, 64'd0);
  endtask

  // One directed access on a single port; latencies are counted in cycles
  // from the edge that samples the request.
  task automatic doAccess(input bit ldr, input bit we, input logic [8:0] addr,
                          input logic [31:0] wdata, output int gnt_lat, output int rv_lat);
    int k = 0;
    gnt_lat = -1;
    rv_lat  = -1;
    waitIdle();
    if (ldr) begin
      in_ldr_req = 1; in_ldr_we = we; in_ldr_addr = addr; in_ldr_wdata = wdata;
    end else begin
      in_cpu_req = 1; in_cpu_we = we; in_cpu_addr = addr; in_cpu_wdata = wdata;
    end
    while (k < 30) begin
      @(negedge clk);
      k++;
      if ((ldr ? out_ldr_gnt : out_cpu_gnt) && gnt_lat < 0) begin
        gnt_lat = k;
        if (ldr) in_ldr_req = 0; else in_cpu_req = 0;
      end
      if (ldr ? out_ldr_rvalid : out_cpu_rvalid) rv_lat = k;
      if ((we && gnt_lat > 0) || rv_lat > 0) break;
    end
    in_cpu_req = 0;
    in_ldr_req = 0;
  endtask

  task automatic agentStep(input int rate, input logic gnt, inout logic req, inout logic we,
                           inout logic [8:0] addr, inout logic [31:0] wdata);
    if ((req && gnt) || !req) begin
      req = ($urandom_range(0, 99) < rate);
      if (req) begin
        we = 1'($urandom_range(0, 1)); addr = rand_addr(); wdata = $urandom;
      end
    end else if ($urandom_range(0, 3) == 0) begin
      // Not yet sampled, so the fields may still change freely.
      addr = rand_addr(); wdata = $urandom;
    end
  endtask

  task automatic applyStimulus(input int rate_cpu, input int rate_ldr, input int cycles,
                               input int rst_rate);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (rst_rate > 0 && $urandom_range(0, 99) < rst_rate) begin
        pulseReset(1 + $urandom_range(0, 2));
      end else begin
        agentStep(rate_cpu, out_cpu_gnt, in_cpu_req, in_cpu_we, in_cpu_addr, in_cpu_wdata);
        agentStep(rate_ldr, out_ldr_gnt, in_ldr_req, in_ldr_we, in_ldr_addr, in_ldr_wdata);
      end
    end
    in_cpu_req = 0;
    in_ldr_req = 0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int g, r, n;
    string exp_order;
    byte got_order [10];

    in_reset_n = 0;
    in_cpu_req = 0; in_cpu_we = 0; in_cpu_addr = '0; in_cpu_wdata = '0;
    in_ldr_req = 0; in_ldr_we = 0; in_ldr_addr = '0; in_ldr_wdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", out_busy, 64'd0);
    checkOutput("reset_ram_en", out_ram_en, 64'd0);
    checkOutput("reset_cpu_rdata", out_cpu_rdata, 64'd0);
    #2 in_reset_n = 1;
    @(negedge clk);

    // CPU write then read back at the same address.
    doAccess(0, 1, 9'h010, 32'hDEADBEEF, g, r);
    checkOutput("t1_wr_gnt_lat", g, 64'd1);
    doAccess(0, 0, 9'h010, 32'h0, g, r);
    checkOutput("t1_rd_gnt_lat", g, 64'd1);
    checkOutput("t1_rd_rv_lat", r, 64'(RL + 2));
    checkOutput("t1_rdata", out_cpu_rdata, 64'hDEADBEEF);

    // Loader read of preloaded 0x1FF leaves the CPU result alone.
    doAccess(1, 0, 9'h1FF, 32'h0, g, r);
    checkOutput("t3_gnt_lat", g, 64'd1);
    checkOutput("t3_rv_lat", r, 64'(RL + 2));
    checkOutput("t3_ldr_rdata", out_ldr_rdata, 64'h12345678);
    checkOutput("t3_cpu_rdata", out_cpu_rdata, 64'hDEADBEEF);

    // Both requesting writes continuously: loader burst then a CPU slot.
    waitIdle();
    exp_order = "LLLLCLLLLC";
    foreach (got_order[i]) got_order[i] = 0;
    in_cpu_req = 1; in_cpu_we = 1; in_cpu_addr = 9'h005; in_cpu_wdata = $urandom;
    in_ldr_req = 1; in_ldr_we = 1; in_ldr_addr = 9'h006; in_ldr_wdata = $urandom;
    n = 0;
    for (int k = 0; k < 60 && n < 10; k++) begin
      @(negedge clk);
      if (out_ldr_gnt) begin
        got_order[n] = "L"; n++;
        in_ldr_addr = rand_addr(); in_ldr_wdata = $urandom;
      end else if (out_cpu_gnt) begin
        got_order[n] = "C"; n++;
        in_cpu_addr = rand_addr(); in_cpu_wdata = $urandom;
      end
    end
    in_cpu_req = 0;
    in_ldr_req = 0;
    for (int i = 0; i < 10; i++)
      checkOutput($sformatf("t2_grant%0d", i), got_order[i], exp_order[i]);

    // Address change after the sampling edge must not reach the RAM.
    waitIdle();
    in_cpu_req = 1; in_cpu_we = 1; in_cpu_addr = 9'h020; in_cpu_wdata = 32'h0000_0055;
    @(negedge clk);
    checkOutput("t5_gnt", out_cpu_gnt, 64'd1);
    checkOutput("t5_addr_issue", out_ram_addr, 64'h020);
    in_cpu_addr = 9'h030;
    in_cpu_req = 0;
    @(negedge clk);
    checkOutput("t5_addr_hold", out_ram_addr, 64'h020);
    doAccess(0, 0, 9'h030, 32'h0, g, r);
    checkOutput("t5_rdata_030", out_cpu_rdata, 64'(init_val(9'h030)));

    // Reset during the wait phase of a CPU read, then normal service.
    waitIdle();
    in_cpu_req = 1; in_cpu_we = 0; in_cpu_addr = 9'h020;
    @(negedge clk);
    checkOutput("t4_gnt", out_cpu_gnt, 64'd1);
    in_cpu_req = 0;
    @(negedge clk);
    pulseReset(2);
    doAccess(0, 0, 9'h020, 32'h0, g, r);
    checkOutput("t4_gnt_lat", g, 64'd1);
    checkOutput("t4_rv_lat", r, 64'(RL + 2));
    checkOutput("t4_rdata", out_cpu_rdata, 64'h55);

    // Idle stretch.
    waitIdle();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("t6_busy", out_busy, 64'd0);
      checkOutput("t6_ram_en", out_ram_en, 64'd0);
    end

    applyStimulus(90, 90, 600, 0);
    applyStimulus(30, 30, 600, 0);
    applyStimulus(95, 60, 600, 0);
    applyStimulus(60, 60, 600, 3);
    waitIdle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
